i2c_slave_regfile: RTL
======================

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 The block SHALL have parameter ADDR, default 7'd101, meaning the 7-bit slave address it responds to.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, meaning the depth of the internal 8-bit register file (2..256).
REQ-003 The block SHALL have parameter PW, default $clog2(NUM_REGS), meaning the width of the register pointer.
REQ-004 The block SHALL have port clk, input, 1, the system clock; it is the only clock, and every flop SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port scl, input, 1, the raw I2C clock line, asynchronous to clk.
REQ-007 The block SHALL have port sda_in, input, 1, the raw I2C data line, asynchronous to clk.
REQ-008 The block SHALL have port sda_oe, output, 1; 1 pulls SDA low (open-drain) and 0 releases it.
REQ-009 The block SHALL have port host_addr, input, PW, the host-side read address.
REQ-010 The block SHALL have port host_rdata, output, 8, the register file contents at host_addr (combinational).
REQ-011 The block SHALL have port wr_strobe, output, 1, a one-clk pulse when a bus write commits a register.
REQ-012 The block SHALL have port wr_ptr, output, PW, the register index written, valid with wr_strobe.
REQ-013 The block SHALL have port busy, output, 1, high from an addressed START until STOP or NACK exit.

Function
REQ-014 The block SHALL pass scl and sda_in through 2-flop synchronisers and a third history flop; all edge detection SHALL use the synchronised values only.
REQ-015 The block SHALL detect START as synchronised SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both SHALL take precedence over any bit activity in the same clk.
REQ-016 The block SHALL have FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK and WAIT_STOP.
REQ-017 A START in any state (including a repeated START) SHALL clear the bit counter and enter ADDR; a STOP in any state SHALL enter IDLE and release sda_oe.
REQ-018 The block SHALL sample SDA on the detected SCL rising edge, MSB first, using a 3-bit counter; the 8th sample completes a byte.
REQ-019 The block SHALL change sda_oe only on the clk following a detected SCL falling edge, never while SCL is high.
REQ-020 ADDR: if byte[7:1]==ADDR, the block SHALL assert ACK (sda_oe=1) from the SCL fall after bit 8 to the SCL fall after bit 9, and latch R/W=byte[0]; on mismatch it SHALL not drive SDA and SHALL go to WAIT_STOP.
REQ-021 After ADDR_ACK, the block SHALL go to PTR when R/W=0 and to RDATA when R/W=1.
REQ-022 PTR: the received byte SHALL load the pointer if it is < NUM_REGS, followed by ACK and a transition to WDATA; otherwise the block SHALL NACK (not drive) and go to WAIT_STOP with the pointer unchanged.
REQ-023 WDATA: each completed byte SHALL be written to regs[ptr], pulse wr_strobe with wr_ptr=ptr on the same clk, then ACK; the pointer SHALL then auto-increment.
REQ-024 RDATA: the block SHALL load regs[ptr] into the shift register at the SCL fall that ends the previous ACK, and drive the bits MSB first, with sda_oe = ~bit.
REQ-025 RACK: the block SHALL release SDA and sample the master ACK; ACK(0) SHALL increment the pointer and return to RDATA, and NACK(1) SHALL go to WAIT_STOP.
REQ-026 Pointer increment SHALL wrap from NUM_REGS-1 to 0.
REQ-027 The pointer SHALL persist across transactions, so a START+addr+R without a pointer write reads from the last pointer.
REQ-028 A write and a host read of the same index in the same clk SHALL return the old value on host_rdata; the new value appears the next clk.
REQ-029 A repeated START mid-byte SHALL discard the partial byte: no register write and no wr_strobe.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL return to IDLE with sda_oe=0, wr_strobe=0, wr_ptr=0, busy=0, pointer=0, all registers=8'h00, and synchroniser flops=1 (bus idle).
REQ-031 Reset asserted mid-transaction SHALL release SDA within one clk, and the block SHALL ignore the bus until the next START.

Verification
REQ-032 The bench SHALL cover: reset, then START, 0xCA (addr 101, W), ptr 0x03, data 0x5A, 0xA5, STOP -> two ACKs after the data bytes, wr_strobe at ptr 3 then 4, host_addr=3 reads 0x5A and host_addr=4 reads 0xA5.
REQ-033 The bench SHALL cover: START, 0xCA, ptr 0x03, repeated START, 0xCB, master ACK, NACK -> slave returns 0x5A then 0xA5, then releases SDA.
REQ-034 The bench SHALL cover: START, 0x80 (addr 64) -> sda_oe stays 0 for the whole transaction, busy=0, no wr_strobe.
REQ-035 The bench SHALL cover, with NUM_REGS=16: write ptr 0x0F, data 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap); ptr 0x10 -> NACK and no write.
REQ-036 The bench SHALL cover: rst pulsed during the 4th data bit of a read -> sda_oe=0 the next clk, all registers=0x00, and the next START+0xCB returns 0x00.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// i2c_slave_regfile
//
// I2C slave that exposes a small 8-bit register file. The whole block runs in
// the clk domain. SCL and SDA are oversampled through synchronisers, and the
// bus protocol is decoded from edges of the synchronised lines.
//
// Bus protocol:
//   write : START, {ADDR,0}, pointer, data, data, ..., STOP
//   read  : START, {ADDR,1}, data, data, ..., STOP
//   The pointer auto-increments after every written byte and after every byte
//   read that the master ACKs. It wraps from NUM_REGS-1 to 0, and it persists
//   across transactions.
//
// Parameters:
//   ADDR      7-bit slave address that this block answers to
//   NUM_REGS  depth of the register file (2..256)
//   PW        width of the register pointer
//
// Ports:
//   clk         system clock; every flop is clocked on its rising edge
//   rst         synchronous, active-high reset
//   scl         raw I2C clock line, asynchronous to clk
//   sda_in      raw I2C data line, asynchronous to clk
//   sda_oe      1 pulls SDA low (open-drain), 0 releases it
//   host_addr   host-side read index
//   host_rdata  regs[host_addr], combinational
//   wr_strobe   one-clk pulse when a bus write commits a register
//   wr_ptr      index of the committed register, valid with wr_strobe
//   busy        high from an address match until STOP or a NACK exit
// -----------------------------------------------------------------------------
module i2c_slave_regfile #(
  parameter logic [6:0] ADDR     = 7'd101,
  parameter int         NUM_REGS = 16,
  parameter int         PW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_ptr,
  output logic          busy
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WACK      = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RACK      = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  // ---------------------------------------------------------------------------
  // Synchronisers: q1/q2 form the two-flop synchroniser, and q3 holds the
  // previous synchronised value for edge detection. They reset to 1, so the
  // bus looks idle coming out of reset and no false edge is seen.
  // ---------------------------------------------------------------------------
  logic scl_q1, scl_q2, scl_q3;
  logic sda_q1, sda_q2, sda_q3;

  // NOTE: sequential state is always updated with non-blocking assignments, so
  // that every flop samples the pre-edge value of the flops that feed it.
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_q3, scl_q2, scl_q1} <= 3'b111;
      {sda_q3, sda_q2, sda_q1} <= 3'b111;
    end else begin
      {scl_q3, scl_q2, scl_q1} <= {scl_q2, scl_q1, scl};
      {sda_q3, sda_q2, sda_q1} <= {sda_q2, sda_q1, sda_in};
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_q2 & ~scl_q3;
  assign scl_fall  = ~scl_q2 &  scl_q3;
  // A START or STOP condition is an SDA edge while SCL is stable high.
  assign start_det = scl_q2 & scl_q3 &  sda_q3 & ~sda_q2;
  assign stop_det  = scl_q2 & scl_q3 & ~sda_q3 &  sda_q2;

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  logic [3:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          rw;
  logic          phase;     // ACK states: ACK driven. RDATA: last bit sent. RACK: master ACKed.
  logic [PW-1:0] ptr;
  logic [7:0]    regs [NUM_REGS];

  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          ptr_ok;
  logic [PW-1:0] ptr_next;
  logic [7:0]    rd_byte;

  // Byte assembled from the shift register plus the bit being sampled now,
  // so that the decision can be taken on the 8th rising edge itself.
  assign rx_byte   = {shift_reg[6:0], sda_q2};
  assign byte_done = (bit_cnt == 3'd7);
  assign ptr_ok    = (int'(rx_byte) < NUM_REGS);
  assign ptr_next  = (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + PW'(1);
  assign rd_byte   = regs[ptr];

  // ---------------------------------------------------------------------------
  // Protocol FSM and register file
  //
  // Received bits are shifted in on SCL rising edges. sda_oe changes only on
  // SCL falling edges, so SDA never moves under a high SCL. The exceptions are
  // START, STOP and reset, each of which releases the line at once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rw        <= 1'b0;
      phase     <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_ptr    <= '0;
      busy      <= 1'b0;
      // NOTE: the register file is reset explicitly because it must read back
      // as all-zero after reset. This forces it into flops rather than RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      wr_strobe <= 1'b0;

      if (start_det) begin
        // A START, first or repeated, abandons any partial byte.
        // busy is left alone: a repeated START inside our own transaction
        // stays busy, and a START to another address clears busy on the
        // mismatch.
        state   <= S_ADDR;
        bit_cnt <= '0;
        phase   <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        phase   <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (rx_byte[7:1] == ADDR) begin
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                  phase <= 1'b0;
                  state <= S_ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= S_WAIT_STOP;
                end
              end
            end
          end

          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= '0;
                if (rw) begin
                  // The first read bit goes out on the same fall that ends
                  // the ACK.
                  shift_reg <= rd_byte;
                  sda_oe    <= ~rd_byte[7];
                  state     <= S_RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= S_PTR;
                end
              end
            end
          end

          S_PTR: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (ptr_ok) begin
                  ptr   <= rx_byte[PW-1:0];
                  phase <= 1'b0;
                  state <= S_PTR_ACK;
                end else begin
                  // The pointer is out of range: NACK by not driving, and
                  // keep the old pointer.
                  busy  <= 1'b0;
                  state <= S_WAIT_STOP;
                end
              end
            end
          end

          S_PTR_ACK, S_WACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= '0;
                state   <= S_WDATA;
              end
            end
          end

          S_WDATA: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (byte_done) begin
                regs[ptr] <= rx_byte;
                wr_strobe <= 1'b1;
                wr_ptr    <= ptr;
                ptr       <= ptr_next;
                phase     <= 1'b0;
                state     <= S_WACK;
              end
            end
          end

          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                phase <= 1'b1;
              end
            end else if (scl_fall) begin
              if (phase) begin
                // All 8 bits are sent. Release SDA so the master can ACK.
                sda_oe <= 1'b0;
                phase  <= 1'b0;
                state  <= S_RACK;
              end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                sda_oe    <= ~shift_reg[6];
              end
            end
          end

          S_RACK: begin
            if (scl_rise) begin
              if (!sda_q2) begin
                ptr   <= ptr_next;
                phase <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= S_WAIT_STOP;
              end
            end else if (scl_fall && phase) begin
              // rd_byte already reflects the incremented pointer, because the
              // rise and this fall are always more than one clk apart.
              shift_reg <= rd_byte;
              sda_oe    <= ~rd_byte[7];
              bit_cnt   <= '0;
              phase     <= 1'b0;
              state     <= S_RDATA;
            end
          end

          S_WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Host read port. A bus write to the same index shows up one clk later,
  // because regs is a flop array.
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of always_comb keeps the output
  // driven on every path, so no latch is inferred.
  always_comb begin
    host_rdata = 8'h00;
    if (int'(host_addr) < NUM_REGS) begin
      host_rdata = regs[host_addr];
    end
  end

endmodule
